lcd_bus_receiver: RTL and testbench

Responder side of the 8-bit HD44780-style parallel bus (rs, rw, enable, data) driven by the team's LCD writer FSMs. It samples bus transactions on the falling edge of enable and decodes instructions. It maintains DDRAM, CGRAM, an address counter and display flags, and models the busy period. Used as a synthesizable on-chip monitor and as the verification target for LCD driver blocks; memory read ports expose the resulting screen contents.

---
 rtl/lcd_bus_receiver_if.sv | 11 +
 rtl/lcd_bus_receiver.sv | 231 +++++++++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_receiver_if.sv
// lcd_bus_receiver_if: HD44780-style parallel bus between an LCD writer and the receiver.
interface lcd_bus_receiver_if;
  logic       rs;
  logic       rw;
  logic       enable;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       busy;
  modport master (output rs, rw, enable, data_in, input data_out, busy);
  modport slave  (input rs, rw, enable, data_in, output data_out, busy);
endinterface

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: HD44780-style bus responder with DDRAM/CGRAM, address counter, busy model and monitor ports.
module lcd_bus_receiver #(
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 1600,
  parameter int DDRAM_DEPTH  = 128,
  parameter int CGRAM_DEPTH  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  lcd_bus_receiver_if.slave    bus,
  output logic                 protocol_err,
  output logic                 display_on,
  output logic                 cursor_on,
  output logic                 blink_on,
  output logic                 lines2,
  output logic                 mode8bit,
  output logic                 inc_dec,
  output logic                 shift_en,
  output logic [6:0]           addr_counter,
  output logic                 ac_in_cgram,
  input  logic [6:0]           ddram_rd_addr,
  output logic [7:0]           ddram_rd_data,
  input  logic [5:0]           cgram_rd_addr,
  output logic [7:0]           cgram_rd_data
);
  localparam int CW = $clog2(CLEAR_CYCLES > BUSY_CYCLES ? CLEAR_CYCLES : BUSY_CYCLES);
  typedef enum logic [1:0] {IDLE, EXEC, BUSY} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    en_q;
  logic [1:0]    rs_q, rw_q;
  logic [7:0]    dat1_q, dat2_q;
  logic          cmd_rs_q, cmd_rs_d, cmd_rw_q, cmd_rw_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [6:0]    ac_q, ac_d;
  logic          cg_q, cg_d;
  logic          disp_q, disp_d, cur_q, cur_d, blk_q, blk_d;
  logic          l2_q, l2_d, m8_q, m8_d, id_q, id_d, sh_q, sh_d;
  logic [7:0]    dout_q, dout_d;
  logic          perr_q, perr_d;
  logic          clr_q, clr_d;
  logic [7:0]    fill_q, fill_d;
  logic          dd_we, cg_we;
  logic [6:0]    dd_wa;
  logic [7:0]    dd_wd;
  logic [7:0]    rd_ram;
  logic          fall;
  logic [7:0]    ddram [DDRAM_DEPTH];
  logic [4:0]    cgram [CGRAM_DEPTH];

  // Address counter step; DDRAM wraps follow the visible line layout.
  function automatic logic [6:0] step(input logic [6:0] a, input logic up, input logic cg, input logic two);
    if (cg)
      return {1'b0, up ? a[5:0] + 6'd1 : a[5:0] - 6'd1};
    if (two)
      return up ? (a == 7'h27 ? 7'h40 : a == 7'h67 ? 7'h00 : a + 7'd1)
                : (a == 7'h40 ? 7'h27 : a == 7'h00 ? 7'h67 : a - 7'd1);
    return up ? (a == 7'h4F ? 7'h00 : a + 7'd1) : (a == 7'h00 ? 7'h4F : a - 7'd1);
  endfunction

  assign fall   = !en_q[1] && en_q[2];
  assign rd_ram = cg_q ? {3'b000, cgram[ac_q[5:0]]} : ddram[ac_q];

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      en_q   <= '0;
      rs_q   <= '0;
      rw_q   <= '0;
      dat1_q <= '0;
      dat2_q <= '0;
    end else begin
      en_q   <= {en_q[1:0], bus.enable};
      rs_q   <= {rs_q[0], bus.rs};
      rw_q   <= {rw_q[0], bus.rw};
      dat1_q <= bus.data_in;
      dat2_q <= dat1_q;
    end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_rs_d = cmd_rs_q;
    cmd_rw_d = cmd_rw_q;
    cmd_d    = cmd_q;
    ac_d     = ac_q;
    cg_d     = cg_q;
    disp_d   = disp_q;
    cur_d    = cur_q;
    blk_d    = blk_q;
    l2_d     = l2_q;
    m8_d     = m8_q;
    id_d     = id_q;
    sh_d     = sh_q;
    dout_d   = dout_q;
    perr_d   = perr_q;
    clr_d    = clr_q;
    fill_d   = fill_q;
    dd_we    = 1'b0;
    cg_we    = 1'b0;
    dd_wa    = ac_q;
    dd_wd    = cmd_q;
    case (state_q)
      IDLE: if (fall) begin
        state_d  = EXEC;
        cmd_rs_d = rs_q[1];
        cmd_rw_d = rw_q[1];
        cmd_d    = dat2_q;
      end
      EXEC: begin
        state_d = cmd_rw_q ? IDLE : BUSY;
        cnt_d   = CW'(BUSY_CYCLES - 1);
        if (cmd_rw_q) begin
          dout_d = cmd_rs_q ? rd_ram : {1'b0, ac_q};
          ac_d   = cmd_rs_q ? step(ac_q, id_q, cg_q, l2_q) : ac_q;
        end else if (cmd_rs_q) begin
          dd_we = !cg_q;
          cg_we = cg_q;
          ac_d  = step(ac_q, id_q, cg_q, l2_q);
        end else if (cmd_q[7]) begin
          ac_d = cmd_q[6:0];
          cg_d = 1'b0;
        end else if (cmd_q[6]) begin
          ac_d = {1'b0, cmd_q[5:0]};
          cg_d = 1'b1;
        end else if (cmd_q[5]) begin
          m8_d = cmd_q[4];
          l2_d = cmd_q[3];
        end else if (cmd_q[4]) begin
          ac_d = cmd_q[3] ? ac_q : step(ac_q, cmd_q[2], cg_q, l2_q);
        end else if (cmd_q[3]) begin
          disp_d = cmd_q[2];
          cur_d  = cmd_q[1];
          blk_d  = cmd_q[0];
        end else if (cmd_q[2]) begin
          id_d = cmd_q[1];
          sh_d = cmd_q[0];
        end else if (cmd_q[1]) begin
          ac_d  = '0;
          cg_d  = 1'b0;
          cnt_d = CW'(CLEAR_CYCLES - 1);
        end else if (cmd_q[0]) begin
          ac_d   = '0;
          cg_d   = 1'b0;
          id_d   = 1'b1;
          cnt_d  = CW'(CLEAR_CYCLES - 1);
          clr_d  = 1'b1;
          fill_d = '0;
        end
      end
      BUSY: begin
        // Clear fills one DDRAM location per busy cycle; CLEAR_CYCLES covers the whole array.
        if (clr_q && fill_q < 8'(DDRAM_DEPTH)) begin
          dd_we  = 1'b1;
          dd_wa  = fill_q[6:0];
          dd_wd  = 8'h20;
          fill_d = fill_q + 8'd1;
        end
        if (fall && !rs_q[1] && rw_q[1])
          dout_d = {1'b1, ac_q};
        else if (fall)
          perr_d = 1'b1;
        state_d = cnt_q == '0 ? IDLE : BUSY;
        clr_d   = cnt_q == '0 ? 1'b0 : clr_q;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cmd_rs_q <= 1'b0;
      cmd_rw_q <= 1'b0;
      cmd_q    <= '0;
      ac_q     <= '0;
      cg_q     <= 1'b0;
      disp_q   <= 1'b0;
      cur_q    <= 1'b0;
      blk_q    <= 1'b0;
      l2_q     <= 1'b0;
      m8_q     <= 1'b1;
      id_q     <= 1'b1;
      sh_q     <= 1'b0;
      dout_q   <= '0;
      perr_q   <= 1'b0;
      clr_q    <= 1'b0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_rs_q <= cmd_rs_d;
      cmd_rw_q <= cmd_rw_d;
      cmd_q    <= cmd_d;
      ac_q     <= ac_d;
      cg_q     <= cg_d;
      disp_q   <= disp_d;
      cur_q    <= cur_d;
      blk_q    <= blk_d;
      l2_q     <= l2_d;
      m8_q     <= m8_d;
      id_q     <= id_d;
      sh_q     <= sh_d;
      dout_q   <= dout_d;
      perr_q   <= perr_d;
      clr_q    <= clr_d;
      fill_q   <= fill_d;
    end

  // Monitor reads sample before the same-edge write, so a collision returns old data.
  always_ff @(posedge clk) begin
    if (dd_we) ddram[dd_wa] <= dd_wd;
    if (cg_we) cgram[ac_q[5:0]] <= cmd_q[4:0];
    ddram_rd_data <= ddram[ddram_rd_addr];
    cgram_rd_data <= {3'b000, cgram[cgram_rd_addr]};
  end

  assign bus.busy     = state_q == BUSY;
  assign bus.data_out = dout_q;
  assign protocol_err = perr_q;
  assign display_on   = disp_q;
  assign cursor_on    = cur_q;
  assign blink_on     = blk_q;
  assign lines2       = l2_q;
  assign mode8bit     = m8_q;
  assign inc_dec      = id_q;
  assign shift_en     = sh_q;
  assign addr_counter = ac_q;
  assign ac_in_cgram  = cg_q;
endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb_lcd_bus_receiver: randomized bus traffic checked against a behavioural LCD controller model.
module tb_lcd_bus_receiver;
  logic clk = 1'b0;
  logic rst;
  logic protocol_err, display_on, cursor_on, blink_on, lines2, mode8bit, inc_dec, shift_en, ac_in_cgram;
  logic [6:0] addr_counter, ddram_rd_addr;
  logic [5:0] cgram_rd_addr;
  logic [7:0] ddram_rd_data, cgram_rd_data;
  int n_chk = 0;
  int n_err = 0;

  lcd_bus_receiver_if bus();

  lcd_bus_receiver dut (
    .clk(clk), .reset(rst), .bus(bus), .protocol_err(protocol_err),
    .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .lines2(lines2), .mode8bit(mode8bit), .inc_dec(inc_dec), .shift_en(shift_en),
    .addr_counter(addr_counter), .ac_in_cgram(ac_in_cgram),
    .ddram_rd_addr(ddram_rd_addr), .ddram_rd_data(ddram_rd_data),
    .cgram_rd_addr(cgram_rd_addr), .cgram_rd_data(cgram_rd_data)
  );

  always #5 clk = ~clk;

  logic [7:0] dd [128];
  logic [4:0] cgm [64];
  logic [6:0] m_ac;
  logic [7:0] m_dout;
  bit m_cg, m_disp, m_cur, m_blk, m_l2, m_m8, m_id, m_sh, m_perr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_ac = 0; m_cg = 0; m_disp = 0; m_cur = 0; m_blk = 0; m_l2 = 0;
    m_m8 = 1; m_id = 1; m_sh = 0; m_perr = 0; m_dout = 0;
  endtask

  // Two-line mode: 80 cells as 40 per line at 0x00 and 0x40, walked as one ring.
  function automatic logic [6:0] m_next(input logic [6:0] a, input bit up, input bit cgt, input bit two);
    int p;
    if (cgt) return 7'((int'(a) + (up ? 1 : 63)) % 64);
    if (!two) return 7'((int'(a) + (up ? 1 : 79)) % 80);
    p = a >= 7'h40 ? int'(a) - 64 + 40 : int'(a);
    p = (p + (up ? 1 : 79)) % 80;
    return 7'(p >= 40 ? p - 40 + 64 : p);
  endfunction

  task automatic m_apply(input bit rs_v, input bit rw_v, input logic [7:0] d, input bit busy_now);
    int hb;
    if (busy_now) begin
      if (!rs_v && rw_v) m_dout = {1'b1, m_ac};
      else m_perr = 1;
      return;
    end
    if (rw_v) begin
      m_dout = !rs_v ? {1'b0, m_ac} : m_cg ? {3'b000, cgm[m_ac[5:0]]} : dd[m_ac];
      if (rs_v) m_ac = m_next(m_ac, m_id, m_cg, m_l2);
      return;
    end
    if (rs_v) begin
      if (m_cg) cgm[m_ac[5:0]] = d[4:0];
      else dd[m_ac] = d;
      m_ac = m_next(m_ac, m_id, m_cg, m_l2);
      return;
    end
    hb = -1;
    for (int i = 0; i < 8; i++) if (d[i]) hb = i;
    case (hb)
      7: begin m_ac = d[6:0]; m_cg = 0; end
      6: begin m_ac = {1'b0, d[5:0]}; m_cg = 1; end
      5: begin m_m8 = d[4]; m_l2 = d[3]; end
      4: if (!d[3]) m_ac = m_next(m_ac, d[2], m_cg, m_l2);
      3: begin m_disp = d[2]; m_cur = d[1]; m_blk = d[0]; end
      2: begin m_id = d[1]; m_sh = d[0]; end
      1: begin m_ac = 0; m_cg = 0; end
      0: begin
        m_ac = 0; m_cg = 0; m_id = 1;
        for (int i = 0; i < 128; i++) dd[i] = 8'h20;
      end
      default: ;
    endcase
  endtask

  task automatic drive(input bit rs_v, input bit rw_v, input logic [7:0] d);
    @(negedge clk);
    bus.rs = rs_v; bus.rw = rw_v; bus.data_in = d; bus.enable = 1;
    repeat (4) @(negedge clk);
    bus.enable = 0;
  endtask

  task automatic idle_bus();
    bus.rs = 0; bus.rw = 0; bus.data_in = 0;
  endtask

  task automatic bus_txn(input bit rs_v, input bit rw_v, input logic [7:0] d);
    drive(rs_v, rw_v, d);
    repeat (5) @(negedge clk);
    idle_bus();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", bus.busy, 0);
  endtask

  task automatic check_state();
    chk("ac", addr_counter, m_ac);
    chk("cgram_tgt", ac_in_cgram, m_cg);
    chk("flags", {display_on, cursor_on, blink_on, lines2, mode8bit, inc_dec, shift_en},
        {m_disp, m_cur, m_blk, m_l2, m_m8, m_id, m_sh});
    chk("perr", protocol_err, m_perr);
  endtask

  task automatic do_txn(input bit rs_v, input bit rw_v, input logic [7:0] d);
    bus_txn(rs_v, rw_v, d);
    m_apply(rs_v, rw_v, d, 0);
    wait_idle();
    check_state();
    if (rw_v) chk("dout", bus.data_out, m_dout);
  endtask

  task automatic check_mem();
    for (int a = 0; a < 128; a++) begin
      @(negedge clk) ddram_rd_addr = 7'(a);
      @(negedge clk) chk($sformatf("ddram[%0h]", a), ddram_rd_data, dd[a]);
    end
    for (int a = 0; a < 64; a++) begin
      @(negedge clk) cgram_rd_addr = 6'(a);
      @(negedge clk) chk($sformatf("cgram[%0h]", a), cgram_rd_data, {3'b000, cgm[a]});
    end
  endtask

  task automatic rand_txn(input bit two);
    int k;
    logic [7:0] d;
    logic [6:0] a;
    k = $urandom_range(0, 10);
    d = 8'($urandom);
    case (k)
      0: begin
        a = two ? ($urandom_range(0, 1) ? 7'($urandom_range(0, 39)) : 7'(64 + $urandom_range(0, 39)))
                : 7'($urandom_range(0, 79));
        do_txn(0, 0, {1'b1, a});
      end
      1: do_txn(0, 0, {2'b01, d[5:0]});
      2, 3, 4: do_txn(1, 0, d);
      5: do_txn(1, 1, d);
      6: do_txn(0, 1, d);
      7: do_txn(0, 0, {6'b000001, d[1:0]});
      8: do_txn(0, 0, {4'b0001, d[3:0]});
      9: do_txn(0, 0, {5'b00001, d[2:0]});
      default: do_txn(0, 0, 8'h00);
    endcase
  endtask

  initial begin
    int cnt;
    idle_bus();
    bus.enable = 0; ddram_rd_addr = 0; cgram_rd_addr = 0; rst = 1;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_dout", bus.data_out, 0);
    check_state();
    do_txn(0, 0, 8'h38);
    do_txn(0, 0, 8'h0C);
    drive(0, 0, 8'h01);
    m_apply(0, 0, 8'h01, 0);
    cnt = 0;
    repeat (1700) begin
      @(negedge clk);
      if (bus.busy) cnt++;
    end
    idle_bus();
    chk("clear_busy_len", cnt, 1600);
    chk("lines2_on", lines2, 1);
    chk("disp_on", display_on, 1);
    check_state();
    check_mem();
    do_txn(0, 0, 8'h40);
    for (int i = 0; i < 64; i++) do_txn(1, 0, 8'($urandom));
    chk("cg_wrap_ac", addr_counter, 0);
    do_txn(0, 0, 8'h40);
    for (int i = 0; i < 8; i++) do_txn(1, 0, 8'hFF);
    chk("cg_ac8", addr_counter, 8);
    for (int a = 0; a < 9; a++) begin
      @(negedge clk) cgram_rd_addr = 6'(a);
      @(negedge clk) chk($sformatf("cg_row%0d", a), cgram_rd_data, a < 8 ? 8'h1F : {3'b000, cgm[8]});
    end
    do_txn(0, 0, 8'hA7);
    do_txn(1, 0, 8'h41);
    do_txn(1, 0, 8'h42);
    chk("ac_after_wrap", addr_counter, 7'h41);
    @(negedge clk) ddram_rd_addr = 7'h27;
    @(negedge clk) chk("dd27", ddram_rd_data, 8'h41);
    ddram_rd_addr = 7'h40;
    @(negedge clk) chk("dd40", ddram_rd_data, 8'h42);
    bus_txn(1, 0, 8'h55);
    m_apply(1, 0, 8'h55, 0);
    bus_txn(0, 1, 8'h00);
    m_apply(0, 1, 8'h00, 1);
    chk("bf_bit", bus.data_out[7], 1);
    chk("bf_dout", bus.data_out, m_dout);
    chk("bf_no_err", protocol_err, 0);
    bus_txn(1, 0, 8'h66);
    m_apply(1, 0, 8'h66, 1);
    chk("perr_set", protocol_err, 1);
    wait_idle();
    check_state();
    do_txn(0, 0, 8'h80);
    do_txn(0, 0, 8'h04);
    do_txn(1, 0, 8'h5A);
    chk("dec_wrap", addr_counter, 7'h67);
    do_txn(1, 1, 8'h00);
    chk("read_step", addr_counter, 7'h66);
    for (int i = 0; i < 150; i++) rand_txn(1);
    do_txn(0, 0, 8'h30);
    do_txn(0, 0, 8'h80);
    for (int i = 0; i < 100; i++) rand_txn(0);
    check_mem();
    drive(0, 0, 8'h01);
    repeat (100) @(negedge clk);
    idle_bus();
    chk("mid_clear_busy", bus.busy, 1);
    rst = 1;
    #1;
    chk("rst_mid_clear", bus.busy, 0);
    m_reset();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check_state();
    do_txn(0, 0, 8'h0C);
    chk("post_rst_perr", protocol_err, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
